// File: rtl/audio_pkg.sv
// Shared types and constants for the audio fetch path.
//   fetch_state_t  - scheduler FSM states
//   AUDIO_DELTA_W  - default sample-delta width
//   AUDIO_ADDR_W   - audio memory address width
package audio_pkg;

  localparam int unsigned AUDIO_DELTA_W = 12;
  localparam int unsigned AUDIO_ADDR_W  = 32;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SELECT,
    FETCH,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/audio_lrclk_edge.sv
// Registers the frame clock and flags its rising edge. Also usable by the channel array,
// so both sides agree on which clk cycle is the frame edge.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   lrclk     - frame clock, synchronous to clk
//   rise      - high in the cycle where lrclk is 1 and was 0 in the previous cycle
module audio_lrclk_edge (
  input  logic clk,
  input  logic rst,
  input  logic lrclk,
  output logic rise
);

  logic oldLrclk;

  always_ff @(posedge clk) begin
    if (rst) begin
      oldLrclk <= 1'b0;
    end else begin
      oldLrclk <= lrclk;
    end
  end

  assign rise = lrclk & ~oldLrclk;

endmodule

// File: rtl/audio_fetch_scheduler.sv
// Shares one memory read port among CHANNELS channel datapaths. Once per lrclk frame it
// fetches every active channel's sample delta and presents all deltas in parallel.
// Ports:
//   clk, rst           - system clock, synchronous active-high reset
//   lrclk              - frame clock; its rising edge starts a frame fetch
//   i_enable           - scheduler enable, sampled only while idle
//   i_channelActive    - per-channel fetch enable
//   i_sampleAddress    - packed per-channel sample addresses (32 bits each)
//   o_sampleDelta      - packed per-channel deltas (DELTA_W bits each)
//   mem_req/mem_addr   - read request, held until mem_ack
//   mem_ack/mem_rdata  - one-cycle acknowledge with read data
//   o_busy             - frame fetch in progress
//   o_frameDone        - one-cycle pulse when a frame completes
// Optional (AUDIO_FETCH_OVERRUN_STATUS_EN defined):
//   i_clearOverrun     - clears the overrun count (wins over a coincident overrun)
//   o_overrunCount     - saturating count of frames abandoned by a new frame edge
module audio_fetch_scheduler
  import audio_pkg::*;
#(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned DELTA_W  = AUDIO_DELTA_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         lrclk,
  input  logic                         i_enable,
  input  logic [CHANNELS-1:0]          i_channelActive,
  input  logic [CHANNELS*AUDIO_ADDR_W-1:0] i_sampleAddress,
  output logic [CHANNELS*DELTA_W-1:0]  o_sampleDelta,
  output logic                         mem_req,
  output logic [AUDIO_ADDR_W-1:0]      mem_addr,
  input  logic                         mem_ack,
  input  logic [15:0]                  mem_rdata,
`ifdef AUDIO_FETCH_OVERRUN_STATUS_EN
  input  logic                         i_clearOverrun,
  output logic [15:0]                  o_overrunCount,
`endif
  output logic                         o_busy,
  output logic                         o_frameDone
);

  // Index must be able to reach CHANNELS, which marks the end of the frame.
  localparam int unsigned IdxW = $clog2(CHANNELS + 1);

  fetch_state_t                 stateQ, stateD;
  logic [IdxW-1:0]              idxQ, idxD;
  logic [CHANNELS*DELTA_W-1:0]  deltaQ, deltaD;
  logic                         memReqQ, memReqD;
  logic [AUDIO_ADDR_W-1:0]      memAddrQ, memAddrD;
  logic                         busyQ, busyD;
  logic                         doneQ, doneD;

  logic                         frameEdge;
  logic                         overrun;
  logic                         curActive;
  logic [AUDIO_ADDR_W-1:0]      curAddr;
  logic                         lastIdx;

  audio_lrclk_edge u_lrclkEdge (
    .clk   (clk),
    .rst   (rst),
    .lrclk (lrclk),
    .rise  (frameEdge)
  );

  // Upper read-data bits carry nothing for this block.
  logic unusedRdataBits;
  assign unusedRdataBits = ^mem_rdata[15:DELTA_W];

  always_comb begin
    curActive = 1'b0;
    curAddr   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (idxQ == IdxW'(k)) begin
        curActive = i_channelActive[k];
        curAddr   = i_sampleAddress[k*AUDIO_ADDR_W +: AUDIO_ADDR_W];
      end
    end
  end

  assign lastIdx = (idxQ == IdxW'(CHANNELS));

  always_comb begin
    stateD   = stateQ;
    idxD     = idxQ;
    deltaD   = deltaQ;
    memReqD  = memReqQ;
    memAddrD = memAddrQ;
    busyD    = busyQ;
    doneD    = 1'b0;
    overrun  = 1'b0;
    unique case (stateQ)
      IDLE: begin
        // Deltas clear on the clock that ends the edge cycle, so channels consume
        // the previous frame's values on the edge itself.
        if (frameEdge && i_enable) begin
          stateD = SETTLE;
          deltaD = '0;
          busyD  = 1'b1;
        end
      end
      SETTLE: begin
        idxD   = '0;
        busyD  = 1'b1;
        stateD = SELECT;
      end
      SELECT: begin
        if (frameEdge) begin
          overrun = 1'b1;
          stateD  = SETTLE;
          deltaD  = '0;
        end else if (lastIdx) begin
          doneD  = 1'b1;
          busyD  = 1'b0;
          stateD = IDLE;
        end else if (!curActive) begin
          idxD = idxQ + IdxW'(1);
        end else begin
          memReqD  = 1'b1;
          memAddrD = curAddr;
          stateD   = FETCH;
        end
      end
      FETCH: begin
        if (frameEdge) begin
          // The request cannot be withdrawn; finish it in DRAIN and drop the data.
          overrun = 1'b1;
          if (mem_ack) begin
            memReqD = 1'b0;
            stateD  = SETTLE;
            deltaD  = '0;
          end else begin
            stateD = DRAIN;
          end
        end else if (mem_ack) begin
          memReqD = 1'b0;
          for (int k = 0; k < CHANNELS; k++) begin
            if (idxQ == IdxW'(k)) begin
              deltaD[k*DELTA_W +: DELTA_W] = mem_rdata[DELTA_W-1:0];
            end
          end
          idxD   = idxQ + IdxW'(1);
          stateD = SELECT;
        end
      end
      DRAIN: begin
        if (mem_ack) begin
          memReqD = 1'b0;
          stateD  = SETTLE;
          deltaD  = '0;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ   <= IDLE;
      idxQ     <= '0;
      deltaQ   <= '0;
      memReqQ  <= 1'b0;
      memAddrQ <= '0;
      busyQ    <= 1'b0;
      doneQ    <= 1'b0;
    end else begin
      stateQ   <= stateD;
      idxQ     <= idxD;
      deltaQ   <= deltaD;
      memReqQ  <= memReqD;
      memAddrQ <= memAddrD;
      busyQ    <= busyD;
      doneQ    <= doneD;
    end
  end

  assign o_sampleDelta = deltaQ;
  assign mem_req       = memReqQ;
  assign mem_addr      = memAddrQ;
  assign o_busy        = busyQ;
  assign o_frameDone   = doneQ;

`ifdef AUDIO_FETCH_OVERRUN_STATUS_EN
  logic [15:0] overrunCountQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      overrunCountQ <= '0;
    end else if (i_clearOverrun) begin
      overrunCountQ <= '0;
    end else if (overrun && (overrunCountQ != 16'hFFFF)) begin
      overrunCountQ <= overrunCountQ + 16'd1;
    end
  end

  assign o_overrunCount = overrunCountQ;
`else
  logic unusedOverrun;
  assign unusedOverrun = overrun;
`endif

endmodule

// File: tb/tb_audio_fetch_scheduler.sv
// Self-checking bench for audio_fetch_scheduler with CHANNELS=4: directed frames, random
// frames against a list-based reference model, reset mid-fetch and frame overruns.
module tb_audio_fetch_scheduler;

  localparam int unsigned CH = 4;
  localparam int unsigned DW = 12;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             lrclk = 1'b0;
  logic             i_enable = 1'b0;
  logic [CH-1:0]    i_channelActive = '0;
  logic [CH*32-1:0] i_sampleAddress = '0;
  logic [CH*DW-1:0] o_sampleDelta;
  logic             mem_req;
  logic [31:0]      mem_addr;
  logic             mem_ack = 1'b0;
  logic [15:0]      mem_rdata = '0;
  logic             o_busy;
  logic             o_frameDone;
`ifdef AUDIO_FETCH_OVERRUN_STATUS_EN
  logic             i_clearOverrun = 1'b0;
  logic [15:0]      o_overrunCount;
`endif

  int          total = 0;
  int          bad = 0;
  int          latency = 2;
  int          cnt = 0;
  int          doneCount = 0;
  logic        busyAtDone = 1'b1;
  logic [31:0] heldAddr = '0;
  logic [31:0] reqLog[$];

  audio_fetch_scheduler #(
    .CHANNELS (CH),
    .DELTA_W  (DW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .lrclk           (lrclk),
    .i_enable        (i_enable),
    .i_channelActive (i_channelActive),
    .i_sampleAddress (i_sampleAddress),
    .o_sampleDelta   (o_sampleDelta),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata),
`ifdef AUDIO_FETCH_OVERRUN_STATUS_EN
    .i_clearOverrun  (i_clearOverrun),
    .o_overrunCount  (o_overrunCount),
`endif
    .o_busy          (o_busy),
    .o_frameDone     (o_frameDone)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memRead(input logic [31:0] a);
    case (a)
      32'h100: return 16'h70AB;
      32'h200: return 16'hAFFF;
      32'h300: return 16'h5800;
      32'h400: return 16'h3001;
      32'h500: return 16'hC123;
      default: return a[15:0] ^ a[31:16] ^ 16'h5A3C;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory: acks after `latency` cycles of a visible request, logs each request once.
  always @(negedge clk) begin
    if (rst) begin
      mem_ack = 1'b0;
      cnt = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
      cnt = 0;
    end else if (mem_req) begin
      if (cnt == 0) begin
        heldAddr = mem_addr;
        reqLog.push_back(mem_addr);
      end else begin
        chk("addrHeld", mem_addr, heldAddr);
      end
      cnt++;
      if (cnt >= latency) begin
        mem_ack = 1'b1;
        mem_rdata = memRead(mem_addr);
      end
    end
  end

  always @(negedge clk) begin
    if (o_frameDone) begin
      doneCount++;
      busyAtDone = o_busy;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulseLrclk();
    lrclk = 1'b1;
    tick();
    lrclk = 1'b0;
  endtask

  task automatic waitDone(input int d0, input int bound);
    int i = 0;
    while (doneCount == d0 && i < bound) begin
      tick();
      i++;
    end
    chk("doneWithinBound", 64'(doneCount != d0), 64'd1);
  endtask

  task automatic runFrame(input logic [CH-1:0] mask, input logic [CH*32-1:0] addrs,
                          input int lat, input bit dropEn);
    int d0;
    logic [31:0] expQ[$];
    logic [15:0] rd;
    logic [CH*DW-1:0] expD;
    latency = lat;
    i_channelActive = mask;
    i_sampleAddress = addrs;
    i_enable = 1'b1;
    reqLog.delete();
    d0 = doneCount;
    expD = '0;
    for (int k = 0; k < CH; k++) begin
      if (mask[k]) begin
        expQ.push_back(addrs[k*32 +: 32]);
        rd = memRead(addrs[k*32 +: 32]);
        expD[k*DW +: DW] = rd[DW-1:0];
      end
    end
    pulseLrclk();
    if (dropEn) i_enable = 1'b0;
    tick(3);
    chk("busyMidFrame", 64'(o_busy), 64'd1);
    waitDone(d0, 400);
    tick(4);
    chk("doneOnce", 64'(doneCount - d0), 64'd1);
    chk("busyAtDone", 64'(busyAtDone), 64'd0);
    chk("reqCount", 64'(reqLog.size()), 64'(expQ.size()));
    for (int j = 0; j < expQ.size() && j < reqLog.size(); j++) begin
      chk("reqAddr", reqLog[j], expQ[j]);
    end
    chk("deltas", o_sampleDelta, expD);
    i_enable = 1'b1;
  endtask

  initial begin
    logic [CH*32-1:0] a1234;
    logic [CH*32-1:0] a500;
    logic [CH*32-1:0] ra;
    logic             leak;
    int               d0;
    int               n;

    for (int k = 0; k < CH; k++) begin
      a1234[k*32 +: 32] = 32'h100 * (k + 1);
      a500[k*32 +: 32]  = 32'h500;
    end

    // Reset values
    i_enable = 1'b1;
    tick(3);
    chk("rstMemReq", 64'(mem_req), 64'd0);
    chk("rstMemAddr", 64'(mem_addr), 64'd0);
    chk("rstDeltas", 64'(o_sampleDelta), 64'd0);
    chk("rstBusy", 64'(o_busy), 64'd0);
    chk("rstDone", 64'(o_frameDone), 64'd0);
`ifdef AUDIO_FETCH_OVERRUN_STATUS_EN
    chk("rstOverrun", 64'(o_overrunCount), 64'd0);
`endif
    rst = 1'b0;
    tick(2);

    // All active, 2-cycle ack, then sparse mask
    runFrame(4'b1111, a1234, 2, 1'b0);
    runFrame(4'b0101, a1234, 2, 1'b0);

    // Deltas hold on the edge cycle, clear the cycle after
    runFrame(4'b1111, a500, 1, 1'b0);
    d0 = doneCount;
    lrclk = 1'b1;
    chk("edgeHold", 64'(o_sampleDelta), 64'h123123123123);
    tick();
    lrclk = 1'b0;
    chk("edgeClear", 64'(o_sampleDelta), 64'd0);
    waitDone(d0, 400);
    tick(2);

    // Disabled scheduler ignores frame edges
    i_enable = 1'b0;
    reqLog.delete();
    d0 = doneCount;
    pulseLrclk();
    tick(20);
    chk("disReqs", 64'(reqLog.size()), 64'd0);
    chk("disDone", 64'(doneCount - d0), 64'd0);
    chk("disDeltas", 64'(o_sampleDelta), 64'h123123123123);
    i_enable = 1'b1;

    // Random frames; enable sometimes drops mid-frame, which must not stop the frame
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < CH; k++) ra[k*32 +: 32] = $urandom;
      runFrame(CH'($urandom), ra, int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
    end

    // Reset while a request is outstanding
    latency = 10;
    i_channelActive = 4'b1111;
    i_sampleAddress = a1234;
    pulseLrclk();
    tick(5);
    chk("preRstReq", 64'(mem_req), 64'd1);
    rst = 1'b1;
    tick();
    chk("midRstReq", 64'(mem_req), 64'd0);
    chk("midRstDeltas", 64'(o_sampleDelta), 64'd0);
    chk("midRstBusy", 64'(o_busy), 64'd0);
    rst = 1'b0;
    tick(2);
    runFrame(4'b1111, a1234, 2, 1'b0);

    // Overruns: 20-cycle ack latency, frame edge every 40 cycles
`ifdef AUDIO_FETCH_OVERRUN_STATUS_EN
    chk("ovrCountStart", 64'(o_overrunCount), 64'd0);
`endif
    latency = 20;
    reqLog.delete();
    d0 = doneCount;
    pulseLrclk();
    tick(39);
    chk("ovrReqHeld", 64'(mem_req), 64'd1);
    chk("ovrAddr", 64'(mem_addr), 64'h200);
    lrclk = 1'b1;
    chk("ovrEdgeDeltas", 64'(o_sampleDelta), 64'h0AB);
    tick();
    lrclk = 1'b0;
    chk("drainReq", 64'(mem_req), 64'd1);
    chk("drainAddr", 64'(mem_addr), 64'h200);
`ifdef AUDIO_FETCH_OVERRUN_STATUS_EN
    chk("ovrCount1", 64'(o_overrunCount), 64'd1);
`endif
    leak = 1'b0;
    for (int i = 0; i < 39; i++) begin
      tick();
      if (o_sampleDelta[CH*DW-1:DW] != '0) leak = 1'b1;
    end
    chk("ovrNoWrite", 64'(leak), 64'd0);
    chk("ovrNoDone", 64'(doneCount - d0), 64'd0);
    chk("ovrRestart", reqLog.size() >= 3 ? 64'(reqLog[2]) : 64'd0, 64'h100);
    pulseLrclk();
    tick(39);
    pulseLrclk();
`ifdef AUDIO_FETCH_OVERRUN_STATUS_EN
    chk("ovrCount3", 64'(o_overrunCount), 64'd3);
`endif
    tick(39);
    lrclk = 1'b1;
`ifdef AUDIO_FETCH_OVERRUN_STATUS_EN
    i_clearOverrun = 1'b1;
`endif
    tick();
    lrclk = 1'b0;
`ifdef AUDIO_FETCH_OVERRUN_STATUS_EN
    i_clearOverrun = 1'b0;
    chk("ovrClearWins", 64'(o_overrunCount), 64'd0);
`endif
    chk("ovrNoDone2", 64'(doneCount - d0), 64'd0);
    waitDone(d0, 400);
    tick(4);
    chk("ovrFinalDone", 64'(doneCount - d0), 64'd1);
    chk("ovrFinalDeltas", 64'(o_sampleDelta), 64'h001800FFF0AB);
    chk("ovrReqTotal", 64'(reqLog.size()), 64'd12);
    n = reqLog.size();
    if (n >= 4) begin
      for (int j = 0; j < 4; j++) begin
        chk("ovrFinalReq", 64'(reqLog[n-4+j]), 64'(32'h100 * (j + 1)));
      end
    end
`ifdef AUDIO_FETCH_OVERRUN_STATUS_EN
    chk("ovrCountFinal", 64'(o_overrunCount), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/audio_fetch_scheduler.md
Name: audio_fetch_scheduler

Overview:
Shares one memory read port among CHANNELS channel datapaths. It fetches each channel's 12-bit sample delta once per lrclk frame and presents all deltas in parallel. Each channel consumes its delta at the next lrclk rising edge. The block sits between the channel array and the audio-memory arbiter port.

Parameters:
CHANNELS, 8, number of channel datapaths served (1..16)
DELTA_W, 12, width of a sample delta; taken from mem_rdata[DELTA_W-1:0]

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
lrclk  in  1  frame clock, synchronous to clk
i_enable  in  1  scheduler enable
i_channelActive  in  CHANNELS  per-channel fetch enable (channel isPlaying)
i_sampleAddress  in  CHANNELS*32  packed next-sample addresses; channel k at [32k+31:32k]
o_sampleDelta  out  CHANNELS*DELTA_W  packed deltas; channel k at [DELTA_W*k+DELTA_W-1:DELTA_W*k]
mem_req  out  1  read request
mem_addr  out  32  read address
mem_ack  in  1  one-cycle acknowledge; mem_rdata valid in the same cycle
mem_rdata  in  16  read data
o_busy  out  1  high while a frame fetch is in progress
o_frameDone  out  1  one-cycle pulse when all channels of a frame are fetched

Behaviour:
- Reset: state IDLE; mem_req=0, mem_addr=0, o_sampleDelta all 0, o_busy=0, o_frameDone=0, internal old_lrclk=0.
- Frame edge: the cycle with old_lrclk==0 and lrclk==1. This is the same cycle in which channels consume o_sampleDelta. o_sampleDelta must not change in that cycle.
- States: IDLE, SETTLE, SELECT, FETCH, DRAIN.
- IDLE: on a frame edge with i_enable=1, go to SETTLE.
- SETTLE (1 cycle): lets channel addresses update.
  - Clear all o_sampleDelta to 0.
  - Index = 0; o_busy=1; go to SELECT.
- SELECT (1 cycle):
  - If index==CHANNELS: pulse o_frameDone, o_busy=0, go to IDLE.
  - Else if i_channelActive[index]==0: delta stays 0, index+1, stay in SELECT.
  - Else: drive mem_addr=i_sampleAddress[index], mem_req=1, go to FETCH.
- FETCH: hold mem_req and mem_addr stable until mem_ack.
  - On mem_ack: write o_sampleDelta[index]=mem_rdata[DELTA_W-1:0]; mem_req=0 in the next cycle; index+1; go to SELECT.
  - Back-to-back requests are therefore separated by one idle cycle.
- Overrun: a frame edge while in SELECT or FETCH.
  - In SELECT: abandon the frame and go to SETTLE next cycle.
  - In FETCH: the outstanding request is never withdrawn. Go to DRAIN, keep mem_req until mem_ack, discard that data, then go to SETTLE.
  - Unfetched channels keep delta 0, so their sample holds.
  - No o_frameDone for an abandoned frame.
- Frame edge in SETTLE: ignored; the frame proceeds normally.
- i_enable=0: checked only in IDLE. A frame in progress completes.
- Reset mid-transaction: immediate return to reset values. The memory side must tolerate a dropped request on reset.
- Frame-edge input with all channels inactive: SETTLE, then CHANNELS+1 SELECT cycles, then o_frameDone.

Optional Feature:
AUDIO_FETCH_OVERRUN_STATUS_EN:
- Defined: adds port o_overrunCount (out, 16), a saturating count of overrun events (saturates at 16'hFFFF), and port i_clearOverrun (in, 1).
  - i_clearOverrun clears the count to 0.
  - If i_clearOverrun and an overrun occur in the same cycle, the clear wins and the count goes to 0.
  - The count resets to 0.
- Undefined: neither port exists; overruns are silently handled as above.

Decomposition:
- audio_pkg holds:
  - typedef enum logic[2:0] fetch_state_t {IDLE, SETTLE, SELECT, FETCH, DRAIN}
  - localparam AUDIO_DELTA_W=12
  - localparam AUDIO_ADDR_W=32
- One sub-module: audio_lrclk_edge, which registers lrclk and outputs a rising-edge pulse. It is reusable by the channel array.

Test Plan:
- CHANNELS=4, all active, addresses 0x100/0x200/0x300/0x400, memory returns 0x0AB/0xFFF/0x800/0x001 with 2-cycle ack latency, one frame edge -> four requests in order, deltas match, o_frameDone exactly one pulse, o_busy falls with it.
- i_channelActive=4'b0101 -> requests only to channels 0 and 2; deltas 1 and 3 read 0 after SETTLE.
- Ack latency 20 cycles, frame period 40 cycles -> overrun. Request to channel 1 held until ack and data discarded; channels 2,3 stay 0; no o_frameDone; new frame begins; count=1 with AUDIO_FETCH_OVERRUN_STATUS_EN.
- Deltas 0x123 present; frame edge -> o_sampleDelta unchanged on the edge cycle, cleared to 0 the cycle after.
- Assert rst while mem_req=1 in FETCH -> next cycle mem_req=0, all deltas 0, state IDLE; the next frame edge restarts normally.
- With AUDIO_FETCH_OVERRUN_STATUS_EN: force 3 overruns, then i_clearOverrun coincident with a 4th -> count reads 3, then 0.
